fir_3path_serializer: RTL and testbench

Output-side companion of `fir_filter_3path`. It accepts one group of three parallel filter results (y0, y1, y2) per handshake and quantizes each to OUT_W bits with round-half-up and saturation. It buffers the quantized groups in a small group FIFO and emits them as a single-rate sample stream, in time order y0 → y1 → y2, over a valid/ready interface. It converts the 3-parallel datapath back to one sample per clock for downstream DAC/capture logic.

---
 rtl/fir_3path_serializer.sv | 158 +++++++++++++++
 tb/tb_fir_3path_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_3path_serializer.sv
// fir_3path_serializer
//
// Output-side companion of the 3-parallel FIR. It accepts one group of three
// parallel results per handshake. Each lane is quantized on write: the lane
// is rounded half-up, arithmetically shifted right by SHIFT, and saturated to
// OUT_W bits. Groups are kept in a small first-word-fall-through group FIFO.
// They leave as a single-rate stream, y0 then y1 then y2.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   in_valid    group y0/y1/y2 present
//   in_ready    group FIFO has room for one more group
//   y0,y1,y2    signed parallel results, y0 oldest
//   out_valid   out_data holds a sample
//   out_ready   downstream accepts out_data
//   out_data    quantized signed sample
//   out_lane    source lane of out_data (0,1,2)
//   fifo_level  groups currently stored (head group counts until its lane 2 leaves)
//   sat_sticky  some accepted sample saturated since reset

module fir_3path_serializer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [IN_W-1:0]       y0,
    input  logic signed [IN_W-1:0]       y1,
    input  logic signed [IN_W-1:0]       y2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [OUT_W-1:0]      out_data,
    output logic        [1:0]            out_lane,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         sat_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    // Clamp limits, expressed in the IN_W+1 bit working width
    localparam logic signed [IN_W:0] Q_MAX =
        $signed({{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [IN_W:0] Q_MIN =
        $signed({{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic [LW-1:0]        level_reg;
    logic [1:0]           lane_reg;
    logic                 sat_reg;
    logic [3*OUT_W-1:0]   mem_reg [DEPTH];

    logic signed [IN_W-1:0] y_arr [3];
    logic [OUT_W-1:0]       q_arr [3];
    logic [2:0]             sat_lane;
    logic [3*OUT_W-1:0]     q_word;
    logic [3*OUT_W-1:0]     head_word;
    logic                   push;
    logic                   beat;
    logic                   pop;

    assign y_arr[0] = y0;
    assign y_arr[1] = y1;
    assign y_arr[2] = y2;

    // Per-lane quantizer: round half-up, shift, saturate
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic signed [IN_W:0] ext;
            logic signed [IN_W:0] t;

            assign ext = {y_arr[gi][IN_W-1], y_arr[gi]};

            if (SHIFT > 0) begin : g_rnd
                localparam logic signed [IN_W:0] RND =
                    (IN_W+1)'(64'(1) << (SHIFT - 1));
                // ext + RND cannot overflow the extra guard bit
                assign t = (ext + RND) >>> SHIFT;
            end else begin : g_pass
                assign t = ext;
            end

            assign sat_lane[gi] = (t > Q_MAX) || (t < Q_MIN);
            assign q_arr[gi]    = (t > Q_MAX) ? Q_MAX[OUT_W-1:0] :
                                  (t < Q_MIN) ? Q_MIN[OUT_W-1:0] :
                                                t[OUT_W-1:0];
        end
    endgenerate

    // Lane 0 occupies the low bits of a stored group word
    assign q_word = {q_arr[2], q_arr[1], q_arr[0]};

    assign in_ready  = (level_reg != LW'(DEPTH));
    assign out_valid = (level_reg != '0);
    assign push      = in_valid && in_ready;
    assign beat      = out_valid && out_ready;
    assign pop       = beat && (lane_reg == 2'd2);

    // First-word-fall-through: the head group is read combinationally so
    // lane 0 appears on the cycle right after the accepting edge.
    assign head_word = mem_reg[rd_ptr_reg];

    always_comb begin
        out_data = head_word[OUT_W-1:0];
        unique case (lane_reg)
            2'd1:    out_data = head_word[2*OUT_W-1:OUT_W];
            2'd2:    out_data = head_word[3*OUT_W-1:2*OUT_W];
            default: out_data = head_word[OUT_W-1:0];
        endcase
    end

    assign out_lane   = lane_reg;
    assign fifo_level = level_reg;
    assign sat_sticky = sat_reg;

    // Storage has no reset; stale contents are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= q_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            lane_reg   <= 2'd0;
            sat_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (|sat_lane) begin
                    sat_reg <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (beat) begin
                lane_reg <= (lane_reg == 2'd2) ? 2'd0 : lane_reg + 2'd1;
            end
            // Simultaneous push and pop leave the level unchanged
            if (push && !pop) begin
                level_reg <= level_reg + LW'(1);
            end else if (pop && !push) begin
                level_reg <= level_reg - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_3path_serializer.sv
// Testbench for fir_3path_serializer. The reference model keeps the expected
// output stream as a queue of samples. Capacity, stream order and latency
// all follow from that queue.
module tb_fir_3path_serializer;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 15;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH+1);

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [IN_W-1:0]   y0, y1, y2;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic [1:0]               out_lane;
    logic [LW-1:0]            fifo_level;
    logic                     sat_sticky;

    fir_3path_serializer #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .fifo_level(fifo_level),
        .sat_sticky(sat_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       lane;
        logic [OUT_W-1:0] data;
    } samp_t;

    samp_t exp_q[$];
    bit    exp_sat;
    int    checks;
    int    failures;

    task automatic check(input string tag, input longint got, input longint expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    // Plain-arithmetic quantizer: floor((y + half) / 2^SHIFT), then clamp
    function automatic logic [OUT_W-1:0] quant(input logic signed [IN_W-1:0] y,
                                               output bit sat);
        longint t;
        longint hi;
        longint lo;
        hi  = (longint'(1) <<< (OUT_W-1)) - 1;
        lo  = -(hi + 1);
        t   = longint'(y);
        if (SHIFT > 0) t = (t + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
        sat = 1'b0;
        if (t > hi) begin
            t = hi; sat = 1'b1;
        end else if (t < lo) begin
            t = lo; sat = 1'b1;
        end
        return t[OUT_W-1:0];
    endfunction

    function automatic int groups_stored();
        return (exp_q.size() + 2) / 3;
    endfunction

    // One clock: check outputs against the model, advance the clock,
    // then apply the accepted push/beat to the model.
    task automatic step(output bit accepted);
        bit                     exp_ready;
        bit                     do_push;
        bit                     do_pop;
        logic signed [IN_W-1:0] ys [3];
        exp_ready = (groups_stored() != DEPTH);
        check("in_ready",   in_ready,   exp_ready);
        check("fifo_level", fifo_level, groups_stored());
        check("out_valid",  out_valid,  exp_q.size() != 0);
        check("sat_sticky", sat_sticky, exp_sat);
        if (exp_q.size() != 0) begin
            check("out_data", out_data, exp_q[0].data);
            check("out_lane", out_lane, exp_q[0].lane);
        end
        do_push = in_valid && exp_ready;
        do_pop  = (exp_q.size() != 0) && out_ready;
        ys[0] = y0; ys[1] = y1; ys[2] = y2;
        @(posedge clk);
        #1;
        if (do_pop) begin
            $display("beat lane=%0d data=%h", exp_q[0].lane, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (do_push) begin
            for (int j = 0; j < 3; j++) begin
                samp_t s;
                bit    st;
                s.lane = 2'(j);
                s.data = quant(ys[j], st);
                if (st) exp_sat = 1'b1;
                exp_q.push_back(s);
            end
            $display("push y0=%h y1=%h y2=%h", ys[0], ys[1], ys[2]);
        end
        accepted = do_push;
    endtask

    task automatic drain();
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(acc);
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        step(acc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"},  out_valid,  0);
        check({tag, "_in_ready"},   in_ready,   1);
        check({tag, "_fifo_level"}, fifo_level, 0);
        check({tag, "_out_lane"},   out_lane,   0);
        check({tag, "_sat_sticky"}, sat_sticky, 0);
    endtask

    initial begin
        bit acc;
        int k;
        checks    = 0;
        failures  = 0;
        exp_sat   = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y0 = '0; y1 = '0; y2 = '0;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_init");
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset released");

        // Rounding
        out_ready = 1'b1;
        y0 = 32'sd32768; y1 = -32'sd49152; y2 = 32'sd16383;
        in_valid = 1'b1;
        step(acc);
        in_valid = 1'b0;
        drain();

        // Saturation; sticky must persist after the drain
        y0 = 32'sh4000_0000; y1 = 32'sh8000_0000; y2 = 32'sh7FFF_FFFF;
        in_valid = 1'b1;
        step(acc);
        drain();

        // Full / backpressure: 5 distinct groups against a stalled sink
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 60 && k < 5; c++) begin
            out_ready = (c >= 6);
            y0 = (100*k + 1) <<< SHIFT;
            y1 = (100*k + 2) <<< SHIFT;
            y2 = (100*k + 3) <<< SHIFT;
            in_valid = 1'b1;
            step(acc);
            if (acc) k++;
        end
        if (k != 5) check("full_accept_count", k, 5);
        out_ready = 1'b1;
        drain();

        // Sustained ramp
        k = 0;
        for (int c = 0; c < 300 && k < 40; c++) begin
            y0 = (3*k)     <<< SHIFT;
            y1 = (3*k + 1) <<< SHIFT;
            y2 = (3*k + 2) <<< SHIFT;
            in_valid = 1'b1;
            step(acc);
            if (acc) k++;
        end
        if (k != 40) check("ramp_accept_count", k, 40);
        drain();

        // Random traffic; the source holds a group until it is accepted
        acc = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (acc || !in_valid) begin
                y0 = $urandom; y1 = $urandom; y2 = $urandom;
                if ($urandom_range(1) == 1) begin
                    y0 = y0 >>> 12; y1 = y1 >>> 12; y2 = y2 >>> 12;
                end
                in_valid = ($urandom_range(3) != 0);
            end
            out_ready = ($urandom_range(3) != 0);
            step(acc);
        end
        out_ready = 1'b1;
        drain();

        // Reset mid-stream with level 2, lane 1, sticky set
        out_ready = 1'b0;
        for (int g = 0; g < 2; g++) begin
            y0 = (7 + g) <<< SHIFT; y1 = (17 + g) <<< SHIFT; y2 = 32'sh7FFF_FFFF;
            in_valid = 1'b1;
            step(acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(acc);
        out_ready = 1'b0;
        step(acc);
        check("pre_rst_lane", out_lane, 1);
        check("pre_rst_level", fifo_level, 2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        exp_q.delete();
        exp_sat = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        $display("reset released");
        out_ready = 1'b1;
        y0 = 32'sd5 <<< SHIFT; y1 = 32'sd6 <<< SHIFT; y2 = 32'sd7 <<< SHIFT;
        in_valid = 1'b1;
        step(acc);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
